// File: rtl/mips_multicycle_control_if.sv
// Control-unit bus: instruction fields and memory handshake in, datapath controls and status out.
interface mips_multicycle_control_if;
    logic [5:0] op_in;
    logic [5:0] func_in;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne_out;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_cntrl;
    logic [3:0] alu_cntrl;
    logic [1:0] pc_source;
    logic       illegal_out;
    logic       timeout_out;
    logic [3:0] state_out;

    modport master (
        input  op_in, func_in, mem_ready,
        output pc_write, pc_write_cond, bne_out, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_cntrl,
               alu_cntrl, pc_source, illegal_out, timeout_out, state_out
    );

    modport slave (
        output op_in, func_in, mem_ready,
        input  pc_write, pc_write_cond, bne_out, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_cntrl,
               alu_cntrl, pc_source, illegal_out, timeout_out, state_out
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with variable-latency memory handshake, memory timeout
// and illegal-instruction trapping.
module mips_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT   = 15,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned ERROR_RECOVER = 0
) (
    input logic                        clk,
    input logic                        reset,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        JR        = 4'd11,
        ERROR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ANDI = 6'h0C, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] F_NOP = 6'h00, F_JR  = 6'h08, F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22, F_NOR = 6'h27, F_SLT = 6'h2A;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal;
    logic             timeout;
    logic             mem_state;
    logic             timed_out;

    // A completing handshake in the limit cycle beats the timeout.
    always_comb begin
        mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
        timed_out = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready &&
                    (wait_cnt == CNT_W'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            if (timed_out) begin
                state   <= ERROR;
                timeout <= 1'b1;
            end else begin
                case (state)
                    FETCH: begin
                        if (bus.mem_ready) state <= DECODE;
                        else wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    DECODE: begin
                        case (bus.op_in)
                            OP_RTYPE: begin
                                case (bus.func_in)
                                    F_NOP:                      state <= FETCH;
                                    F_ADD, F_SUB, F_SLT, F_NOR: state <= EXEC_R;
                                    F_JR:                       state <= JR;
                                    default: begin
                                        state   <= ERROR;
                                        illegal <= 1'b1;
                                    end
                                endcase
                            end
                            OP_ADDI, OP_ANDI, OP_LUI: state <= EXEC_I;
                            OP_LW, OP_SW:             state <= MEM_ADDR;
                            OP_BEQ, OP_BNE:           state <= BRANCH;
                            OP_J:                     state <= JUMP;
                            default: begin
                                state   <= ERROR;
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                    MEM_ADDR: state <= (bus.op_in == OP_LW) ? MEM_READ : MEM_WRITE;
                    MEM_READ: begin
                        if (bus.mem_ready) state <= MEM_WB;
                        else wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    MEM_WRITE: begin
                        if (bus.mem_ready) state <= FETCH;
                        else wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    EXEC_R, EXEC_I:                 state <= ALU_WB;
                    MEM_WB, ALU_WB, BRANCH, JUMP, JR: state <= FETCH;
                    ERROR: begin
                        if (ERROR_RECOVER != 0) state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    // Outputs decode straight from the state register so an asynchronous reset
    // silences every control line in the same delta.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.bne_out       = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.ext_cntrl     = 1'b0;
        bus.alu_cntrl     = 4'b0000;
        bus.pc_source     = 2'b00;
        if (!reset) begin
            case (state)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_cntrl = 4'b0010;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_b = 2'b11;
                    bus.ext_cntrl = 1'b1;
                    bus.alu_cntrl = 4'b0010;
                end
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.ext_cntrl = 1'b1;
                    bus.alu_cntrl = 4'b0010;
                end
                MEM_READ: begin
                    bus.iord     = 1'b1;
                    bus.mem_read = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    case (bus.func_in)
                        F_SUB:   bus.alu_cntrl = 4'b0110;
                        F_SLT:   bus.alu_cntrl = 4'b0111;
                        F_NOR:   bus.alu_cntrl = 4'b1100;
                        default: bus.alu_cntrl = 4'b0010;
                    endcase
                end
                EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    case (bus.op_in)
                        OP_ANDI: bus.alu_cntrl = 4'b0000;
                        OP_LUI:  bus.alu_cntrl = 4'b1111;
                        default: begin
                            bus.ext_cntrl = 1'b1;
                            bus.alu_cntrl = 4'b0010;
                        end
                    endcase
                end
                ALU_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = (bus.op_in == OP_RTYPE);
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_cntrl     = 4'b0110;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.bne_out       = (bus.op_in == OP_BNE);
                end
                JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                end
                JR: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b11;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.state_out   = state;
        bus.illegal_out = illegal;
        bus.timeout_out = timeout;
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: two controllers (terminal and recovering ERROR) driven in lockstep,
// each cycle compared against an instruction-level model of the expected state path.
module tb_mips_multicycle_control;
    localparam int unsigned T = 3;

    typedef struct packed {
        logic       pc_write, pc_write_cond, bne_out, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_cntrl;
        logic [3:0] alu_cntrl;
        logic [1:0] pc_source;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       ill;
        logic       to;
    } cyc_t;

    typedef enum int {K_NOP, K_R, K_JR, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, func;
    logic       mem_ready;
    int         sel;
    int         asserts = 0;
    int         failures = 0;
    logic       exp_ill = 1'b0, exp_to = 1'b0;
    bit         err;
    cyc_t       plan[$];
    ctl_t       obs_ctl;
    logic [3:0] obs_st;
    logic [1:0] obs_fl;

    always #5 clk = ~clk;

    mips_multicycle_control_if bus_a ();
    mips_multicycle_control_if bus_b ();

    assign bus_a.op_in = op;
    assign bus_a.func_in = func;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.op_in = op;
    assign bus_b.func_in = func;
    assign bus_b.mem_ready = mem_ready;

    mips_multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(4), .ERROR_RECOVER(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.master));
    mips_multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(4), .ERROR_RECOVER(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.master));

    always_comb begin
        if (sel == 0) begin
            obs_ctl = {bus_a.pc_write, bus_a.pc_write_cond, bus_a.bne_out, bus_a.iord, bus_a.mem_read,
                       bus_a.mem_write, bus_a.ir_write, bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reg_write,
                       bus_a.alu_src_a, bus_a.alu_src_b, bus_a.ext_cntrl, bus_a.alu_cntrl, bus_a.pc_source};
            obs_st = bus_a.state_out;
            obs_fl = {bus_a.illegal_out, bus_a.timeout_out};
        end else begin
            obs_ctl = {bus_b.pc_write, bus_b.pc_write_cond, bus_b.bne_out, bus_b.iord, bus_b.mem_read,
                       bus_b.mem_write, bus_b.ir_write, bus_b.reg_dst, bus_b.mem_to_reg, bus_b.reg_write,
                       bus_b.alu_src_a, bus_b.alu_src_b, bus_b.ext_cntrl, bus_b.alu_cntrl, bus_b.pc_source};
            obs_st = bus_b.state_out;
            obs_fl = {bus_b.illegal_out, bus_b.timeout_out};
        end
    end

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: begin
                case (f)
                    6'h00: return K_NOP;
                    6'h20, 6'h22, 6'h2A, 6'h27: return K_R;
                    6'h08: return K_JR;
                    default: return K_ILL;
                endcase
            end
            6'h08, 6'h0C, 6'h0F: return K_I;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04, 6'h05: return K_BR;
            6'h02: return K_J;
            default: return K_ILL;
        endcase
    endfunction

    // Control word expected in a given state, straight from the per-state output table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                                     input logic rdy);
        ctl_t c;
        c = '0;
        case (st)
            4'd0: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_cntrl = 4'b0010;
                c.ir_write = rdy; c.pc_write = rdy;
            end
            4'd1: begin c.alu_src_b = 2'b11; c.ext_cntrl = 1'b1; c.alu_cntrl = 4'b0010; end
            4'd2: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_cntrl = 1'b1; c.alu_cntrl = 4'b0010;
            end
            4'd3: begin c.iord = 1'b1; c.mem_read = 1'b1; end
            4'd4: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            4'd5: begin c.iord = 1'b1; c.mem_write = 1'b1; end
            4'd6: begin
                c.alu_src_a = 1'b1;
                c.alu_cntrl = (f == 6'h22) ? 4'b0110 : (f == 6'h2A) ? 4'b0111 :
                              (f == 6'h27) ? 4'b1100 : 4'b0010;
            end
            4'd7: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                c.ext_cntrl = (o == 6'h08);
                c.alu_cntrl = (o == 6'h08) ? 4'b0010 : (o == 6'h0C) ? 4'b0000 : 4'b1111;
            end
            4'd8: begin c.reg_write = 1'b1; c.reg_dst = (o == 6'h00); end
            4'd9: begin
                c.alu_src_a = 1'b1; c.alu_cntrl = 4'b0110; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.bne_out = (o == 6'h05);
            end
            4'd10: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            4'd11: begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic void push_cyc(input logic [3:0] s, input logic r);
        plan.push_back('{st: s, rdy: r, ill: exp_ill, to: exp_to});
    endfunction

    // A memory phase with w idle cycles before mem_ready; beyond the limit it times out.
    function automatic void push_wait(input logic [3:0] s, input int unsigned w);
        int unsigned held;
        held = (w > T) ? T + 1 : w + 1;
        for (int unsigned i = 0; i < held; i++) push_cyc(s, (i == w));
        if (w > T) begin
            exp_to = 1'b1;
            err = 1'b1;
        end
    endfunction

    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input int unsigned fw, input int unsigned mw);
        kind_t k;
        ctl_t  e;
        k = classify(o, f);
        plan.delete();
        err = 1'b0;
        push_wait(4'd0, fw);
        if (!err) begin
            push_cyc(4'd1, 1'($urandom_range(0, 1)));
            case (k)
                K_R:  begin push_cyc(4'd6, 1'($urandom_range(0, 1))); push_cyc(4'd8, 1'($urandom_range(0, 1))); end
                K_I:  begin push_cyc(4'd7, 1'($urandom_range(0, 1))); push_cyc(4'd8, 1'($urandom_range(0, 1))); end
                K_JR: push_cyc(4'd11, 1'($urandom_range(0, 1)));
                K_LW: begin
                    push_cyc(4'd2, 1'($urandom_range(0, 1)));
                    push_wait(4'd3, mw);
                    if (!err) push_cyc(4'd4, 1'($urandom_range(0, 1)));
                end
                K_SW: begin
                    push_cyc(4'd2, 1'($urandom_range(0, 1)));
                    push_wait(4'd5, mw);
                end
                K_BR: push_cyc(4'd9, 1'($urandom_range(0, 1)));
                K_J:  push_cyc(4'd10, 1'($urandom_range(0, 1)));
                K_ILL: begin exp_ill = 1'b1; err = 1'b1; end
                default: ;
            endcase
        end
        if (err) begin
            push_cyc(4'd12, 1'($urandom_range(0, 1)));
            if (sel != 0) push_cyc(4'd0, 1'b0);
            else push_cyc(4'd12, 1'($urandom_range(0, 1)));
        end
        foreach (plan[i]) begin
            @(negedge clk);
            if (i == 0) begin
                op = o;
                func = f;
            end
            mem_ready = plan[i].rdy;
            #1;
            e = exp_ctl(plan[i].st, o, f, plan[i].rdy);
            asserts++;
            if ({obs_st, obs_ctl, obs_fl} !== {plan[i].st, e, plan[i].ill, plan[i].to}) begin
                failures++;
                $display("FAIL %s dut%0d cycle %0d: got state=%0d ctl=%h flags=%b, want state=%0d ctl=%h flags=%b",
                         name, sel, i, obs_st, obs_ctl, obs_fl, plan[i].st, e, {plan[i].ill, plan[i].to});
            end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 6'h23;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            asserts++;
            if ({obs_st, obs_ctl, obs_fl} !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got state=%0d ctl=%h flags=%b, want all zero",
                         s, obs_st, obs_ctl, obs_fl);
            end
        end
        sel = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
        run_instr("post_reset_add", 6'h00, 6'h20, 1, 0);
        run_instr("tail", 6'h00, 6'h00, 0, 0);
    endtask

    task automatic test_alu;
        sel = 0;
        do_reset();
        run_instr("add", 6'h00, 6'h20, 0, 0);
        run_instr("sub", 6'h00, 6'h22, 0, 0);
        run_instr("slt", 6'h00, 6'h2A, 2, 0);
        run_instr("nor", 6'h00, 6'h27, 0, 0);
        run_instr("addi", 6'h08, 6'h15, 0, 0);
        run_instr("andi", 6'h0C, 6'h3F, 1, 0);
        run_instr("lui", 6'h0F, 6'h00, 0, 0);
        run_instr("nop", 6'h00, 6'h00, 0, 0);
        run_instr("tail", 6'h00, 6'h00, 0, 0);
    endtask

    task automatic test_lw_wait;
        sel = 0;
        do_reset();
        run_instr("lw_wait2", 6'h23, 6'h00, 0, 2);
        run_instr("lw_nowait", 6'h23, 6'h11, 0, 0);
        run_instr("sw_wait1", 6'h2B, 6'h00, 0, 1);
        run_instr("tail", 6'h00, 6'h00, 0, 0);
    endtask

    task automatic test_branch_jump;
        sel = 1;
        do_reset();
        run_instr("bne", 6'h05, 6'h00, 0, 0);
        run_instr("beq", 6'h04, 6'h00, 0, 0);
        run_instr("j", 6'h02, 6'h2A, 0, 0);
        run_instr("jr", 6'h00, 6'h08, 0, 0);
        run_instr("tail", 6'h00, 6'h00, 0, 0);
    endtask

    task automatic test_illegal;
        sel = 0;
        do_reset();
        run_instr("illegal_op_stuck", 6'h3F, 6'h00, 0, 0);
        sel = 1;
        do_reset();
        run_instr("illegal_op_recover", 6'h3F, 6'h00, 0, 0);
        sel = 0;
        do_reset();
        run_instr("illegal_func", 6'h00, 6'h3F, 0, 0);
        do_reset();
    endtask

    task automatic test_timeout;
        sel = 0;
        do_reset();
        run_instr("sw_timeout", 6'h2B, 6'h00, 0, 99);
        do_reset();
        run_instr("sw_ready_at_limit", 6'h2B, 6'h00, 0, T);
        run_instr("lw_timeout", 6'h23, 6'h00, 0, T + 1);
        sel = 1;
        do_reset();
        run_instr("fetch_timeout_recover", 6'h00, 6'h20, T + 1, 0);
        do_reset();
    endtask

    task automatic test_reset_mid_write;
        sel = 1;
        do_reset();
        run_instr("ill_before_sw", 6'h3F, 6'h00, 0, 0);
        @(negedge clk);
        op = 6'h2B;
        func = 6'h00;
        mem_ready = 1'b1;
        #1;
        asserts++;
        if (obs_st !== 4'd0 || obs_ctl.ir_write !== 1'b1 || obs_fl !== 2'b10) begin
            failures++;
            $display("FAIL sw_fetch: got state=%0d ir_write=%b flags=%b, want state=0 ir_write=1 flags=10",
                     obs_st, obs_ctl.ir_write, obs_fl);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        asserts++;
        if (obs_st !== 4'd5 || obs_ctl.mem_write !== 1'b1) begin
            failures++;
            $display("FAIL sw_in_write: got state=%0d mem_write=%b, want state=5 mem_write=1",
                     obs_st, obs_ctl.mem_write);
        end
        #1;
        reset = 1'b1;
        #1;
        asserts++;
        if ({obs_st, obs_ctl, obs_fl} !== '0) begin
            failures++;
            $display("FAIL async_reset_drop: got state=%0d ctl=%h flags=%b, want all zero",
                     obs_st, obs_ctl, obs_fl);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
        @(negedge clk);
        #1;
        asserts++;
        if (obs_st !== 4'd0 || obs_fl !== 2'b00 || obs_ctl.mem_read !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_release: got state=%0d flags=%b mem_read=%b, want state=0 flags=00 mem_read=1",
                     obs_st, obs_fl, obs_ctl.mem_read);
        end
        run_instr("tail", 6'h00, 6'h00, 0, 0);
    endtask

    task automatic test_random;
        logic [11:0] legal [13];
        logic [11:0] pick;
        int unsigned fw, mw;
        legal = '{ {6'h00, 6'h00}, {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h27},
                   {6'h00, 6'h08}, {6'h08, 6'h00}, {6'h0C, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00},
                   {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00} };
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) pick = 12'($urandom_range(0, 4095));
            else if ($urandom_range(0, 12) == 0) pick = {6'h02, 6'($urandom_range(0, 63))};
            else pick = legal[$urandom_range(0, 12)];
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            sel = int'($urandom_range(0, 1));
            run_instr("random", pick[11:6], pick[5:0], fw, mw);
            if (err) do_reset();
        end
        run_instr("random_tail", 6'h00, 6'h00, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        op = 6'h00;
        func = 6'h00;
        mem_ready = 1'b0;
        sel = 0;
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
